branch_tag_mgr: RTL
===================

// Module: branch_tag_mgr
// PURPOSE
//  Allocates and frees the 3-bit branch IDs (bid) that tag in-flight branches. Sits between dispatch
//  (up to 2 branches/cycle) and branch_ctrl (4 resolve ports plus one flush).
//  Keeps tags in program order in a circular ring. Retires resolved tags from the oldest end.
//  On a mispredict flush it kills every tag younger than the flushing bid.
// PARAMETERS
//  NUM_TAGS  8  number of branch tags / ring entries (power of 2)
//  TAG_W     3  bid width, log2(NUM_TAGS)
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst_n        in   1         synchronous reset, active low
//  alloc_req    in   2         [0]=dispatch slot0 branch, [1]=slot1 branch (ignored unless [0]=1)
//  alloc_gnt    out  2         per-slot grant, combinational from registered state
//  alloc_tag0   out  TAG_W     bid given to slot0 (=tail)
//  alloc_tag1   out  TAG_W     bid given to slot1 (=tail+1 mod NUM_TAGS)
//  stall        out  1         some requesting slot not granted; dispatch holds
//  resolve_vld  in   4         per exec port: branch resolved, predicted correctly
//  resolve_bid  in   4*TAG_W   bid per port, port k at [k*TAG_W +: TAG_W]
//  flush        in   1         mispredict from branch_ctrl
//  flush_bid    in   TAG_W     bid of the mispredicted branch
//  kill_mask    out  NUM_TAGS  registered 1-cycle pulse: tags squashed by last flush
//  busy_mask    out  NUM_TAGS  registered: tags currently allocated
//  free_cnt     out  TAG_W+1   NUM_TAGS - count, registered state
// BEHAVIOUR
//  - State: head, tail (TAG_W), count (0..NUM_TAGS), valid[N], resolved[N].
//  - Tag value = ring index. Oldest is head; tail is the next free slot.
//  - Reset (rst_n=0 at edge): head=tail=count=0, valid=resolved=0, kill_mask=0.
//    So busy_mask=0, free_cnt=NUM_TAGS, gnt=0. A mid-operation reset discards all tags; flush is ignored.
//  - Grant: gnt[0]=req[0] & free_cnt>=1 & !flush. gnt[1]=req[1] & req[0] & free_cnt>=2 & !flush.
//    stall=(req[0]&!gnt[0]) | (req[1]&req[0]&!gnt[1]).
//    Same-cycle retires do NOT raise free_cnt for grant.
//  - Alloc: each granted tag gets valid=1, resolved=0. tail += popcount(gnt). count updates next edge.
//  - Resolve: port k sets resolved[bid] only if valid[bid]=1 and the tag is not killed this cycle.
//    Otherwise the port is ignored. Duplicate bids on several ports are harmless.
//  - Retire, from registered state: if valid[head]&resolved[head], free head. If also
//    valid[head+1]&resolved[head+1], free that too (max 2/cycle).
//    Freed: valid=resolved=0. head += retired.
//  - Flush, when flush=1 & valid[flush_bid]:
//    - Killed = ring positions flush_bid+1 .. tail-1, mod NUM_TAGS (may be empty). Clear their valid/resolved.
//    - tail = flush_bid+1. resolved[flush_bid]=1, so it retires normally later.
//    - kill_mask <= killed set next cycle, then 0.
//  - Flush with valid[flush_bid]=0: ignored entirely; kill_mask stays 0. Alloc is still blocked that cycle.
//  - Flush + retire, same cycle: retire of entries older than or equal to flush_bid proceeds.
//    count_next = ((flush_bid-head) mod N)+1 - retired.
//  - No flush: count_next = count + allocs - retired.
//  - Full: count==N -> free_cnt=0; all requests stall. Empty: count==0 -> no retire.
//  - Pointers wrap mod NUM_TAGS. count disambiguates full vs empty when head==tail.
//  - Retire latency: resolve at cycle t -> resolved visible t+1 -> freed (busy bit clear) at t+2.
// TESTING
//  1. Reset, then req=11 -> gnt=11, tags 0,1. Next cycle busy_mask=0x03, free_cnt=6.
//  2. Allocate 8 tags, then req=01 -> gnt=00, stall=1, free_cnt=0. Hold: no state change.
//  3. Tags 0-3 busy. Resolve 2: no retire. Resolve 0: tag0 freed.
//     Resolve 1: tags 1,2 freed in one cycle -> busy_mask=0x08.
//  4. Tags 0-5 busy, flush_bid=2 -> next cycle kill_mask=0x38 (one cycle), busy_mask=0x07.
//     The next grant returns tag 3.
//  5. Wrap: head=6, tags 6,7,0,1 busy, flush_bid=7 -> kill_mask=0x03, busy=0xC0, free_cnt=6.
//  6. Same cycle: flush_bid=1 (tags 0-3 busy), req=01, resolve tag 3 -> gnt=0, resolve ignored,
//     busy=0x03. Then rst_n=0 mid-run -> busy_mask=0, free_cnt=8 after the edge.

Source files
------------

// File: rtl/branch_tag_mgr.sv
// Branch tag ring: hands out bids in program order, retires resolved tags from the
// oldest end (up to two per cycle), and squashes everything younger than a mispredicted bid.
module branch_tag_mgr #(
    parameter int NUM_TAGS = 8,
    parameter int TAG_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            alloc_req,
    output logic [1:0]            alloc_gnt,
    output logic [TAG_W-1:0]      alloc_tag0,
    output logic [TAG_W-1:0]      alloc_tag1,
    output logic                  stall,
    input  logic [3:0]            resolve_vld,
    input  logic [4*TAG_W-1:0]    resolve_bid,
    input  logic                  flush,
    input  logic [TAG_W-1:0]      flush_bid,
    output logic [NUM_TAGS-1:0]   kill_mask,
    output logic [NUM_TAGS-1:0]   busy_mask,
    output logic [TAG_W:0]        free_cnt
);
    localparam logic [TAG_W:0] NUM_L = (TAG_W+1)'(NUM_TAGS);

    logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]      count_q, count_d;
    logic [NUM_TAGS-1:0] valid_q, valid_d, resolved_q, resolved_d, kill_q, kill_d;

    logic                flush_v, ret0, ret1;
    logic [TAG_W-1:0]    head_p1, kill_start, kill_len;
    logic [TAG_W:0]      n_alloc, n_ret;
    logic [NUM_TAGS-1:0] killed;

    assign free_cnt   = NUM_L - count_q;
    assign alloc_tag0 = tail_q;
    assign alloc_tag1 = tail_q + TAG_W'(1);
    assign busy_mask  = valid_q;
    assign kill_mask  = kill_q;

    always_comb begin
        alloc_gnt[0] = alloc_req[0] & (free_cnt != '0) & ~flush;
        alloc_gnt[1] = alloc_req[1] & alloc_req[0] & (free_cnt >= (TAG_W+1)'(2)) & ~flush;
        stall = (alloc_req[0] & ~alloc_gnt[0]) | (alloc_req[1] & alloc_req[0] & ~alloc_gnt[1]);
        n_alloc = {{TAG_W{1'b0}}, alloc_gnt[0]} + {{TAG_W{1'b0}}, alloc_gnt[1]};

        // Killed range is flush_bid+1 .. tail-1 around the ring; empty when flush_bid is youngest.
        flush_v    = flush & valid_q[flush_bid];
        kill_start = flush_bid + TAG_W'(1);
        kill_len   = tail_q - kill_start;
        killed     = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            killed[i] = flush_v & ((TAG_W'(i) - kill_start) < kill_len);

        // Second retire must not take an entry the same-cycle flush is squashing.
        head_p1 = head_q + TAG_W'(1);
        ret0    = valid_q[head_q] & resolved_q[head_q];
        ret1    = ret0 & valid_q[head_p1] & resolved_q[head_p1] & ~killed[head_p1];
        n_ret   = {{TAG_W{1'b0}}, ret0} + {{TAG_W{1'b0}}, ret1};

        valid_d    = valid_q;
        resolved_d = resolved_q;
        for (int k = 0; k < 4; k++)
            if (resolve_vld[k] && valid_q[resolve_bid[k*TAG_W +: TAG_W]]
                && !killed[resolve_bid[k*TAG_W +: TAG_W]])
                resolved_d[resolve_bid[k*TAG_W +: TAG_W]] = 1'b1;
        if (flush_v)
            resolved_d[flush_bid] = 1'b1;
        valid_d    = valid_d & ~killed;
        resolved_d = resolved_d & ~killed;
        if (ret0) begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
        end
        if (ret1) begin
            valid_d[head_p1]    = 1'b0;
            resolved_d[head_p1] = 1'b0;
        end
        if (alloc_gnt[0]) begin
            valid_d[alloc_tag0]    = 1'b1;
            resolved_d[alloc_tag0] = 1'b0;
        end
        if (alloc_gnt[1]) begin
            valid_d[alloc_tag1]    = 1'b1;
            resolved_d[alloc_tag1] = 1'b0;
        end

        head_d  = head_q + n_ret[TAG_W-1:0];
        tail_d  = flush_v ? kill_start : tail_q + n_alloc[TAG_W-1:0];
        count_d = flush_v ? ({1'b0, flush_bid - head_q} + (TAG_W+1)'(1) - n_ret)
                          : (count_q + n_alloc - n_ret);
        kill_d  = killed;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            resolved_q <= '0;
            kill_q     <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            kill_q     <= kill_d;
        end
    end
endmodule
